// File: rtl/exmemory_bus_pkg.sv
// Shared encodings for the exmemory_bus memory subsystem: region codes,
// FSM states, access kinds and the wait-counter width.
package exmemory_bus_pkg;

    localparam int WAIT_W = 4;

    localparam logic [3:0] RGN_ROM = 4'h0;
    localparam logic [3:0] RGN_RAM = 4'h1;
    localparam logic [3:0] RGN_IO  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        KIND_ROM,
        KIND_RAM,
        KIND_IO,
        KIND_NONE
    } kind_e;

endpackage

// File: rtl/exmemory_bus_ram.sv
// Single-port synchronous RAM with per-byte write enables. The read register
// only updates on a read, so it holds the last read word between accesses.
module exmemory_bus_ram #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH),
    localparam int NB    = WIDTH / 8
) (
    input  logic             clk,
    input  logic             i_re,
    input  logic [NB-1:0]    i_be,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (i_be[b]) begin
                r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/exmemory_bus.sv
// Memory subsystem on the CPU memory port: ROM / RAM / I/O decode, per-region
// wait states, byte-enable writes and an error response for illegal accesses.
module exmemory_bus
    import exmemory_bus_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int RAM_DEPTH  = 1024,
    parameter int NUM_IO     = 4,
    parameter int ROM_WAIT   = 0,
    parameter int RAM_WAIT   = 1,
    parameter int IO_WAIT    = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_write,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [WIDTH-1:0]        i_req_wdata,
    input  logic [WIDTH/8-1:0]      i_req_be,
    output logic                    o_resp_valid,
    output logic [WIDTH-1:0]        o_resp_rdata,
    output logic                    o_resp_err,
    output logic [9:0]              o_rom_addr,
    input  logic [31:0]             i_rom_data,
    output logic [NUM_IO*WIDTH-1:0] o_io_out,
    input  logic [NUM_IO*WIDTH-1:0] i_io_in
);

    localparam int NB     = WIDTH / 8;
    localparam int RAM_AW = $clog2(RAM_DEPTH);

    state_e              r_state, w_next;
    kind_e               r_kind, w_kind;
    logic [WAIT_W-1:0]   r_wait_cnt, w_wait;
    logic                r_err, w_err;
    logic                r_write;
    logic [9:0]          r_word;
    logic [WIDTH-1:0]    r_wdata;
    logic [NB-1:0]       r_be;
    logic [3:0]          w_region;
    logic [9:0]          w_word;
    logic                w_accept;

    logic [WIDTH-1:0]    r_io_out [NUM_IO];
    logic [WIDTH-1:0]    w_io_in_sel;
    logic [WIDTH-1:0]    r_resp_rdata;
    logic                r_resp_err;
    logic                r_rdata_ram;
    logic                w_ram_re;
    logic [NB-1:0]       w_ram_be;
    logic [WIDTH-1:0]    w_ram_rdata;

    assign w_region    = i_req_addr[ADDR_WIDTH-1 -: 4];
    assign w_word      = i_req_addr[11:2];
    assign o_req_ready = (r_state == ST_IDLE) && reset;
    assign w_accept    = o_req_ready && i_req_valid;

    // The I/O window is only NUM_IO words wide; any offset bit above the
    // 16-register index field makes the access illegal.
    always_comb begin
        w_kind = KIND_NONE;
        w_wait = '0;
        w_err  = 1'b0;
        case (w_region)
            RGN_ROM: begin
                w_kind = KIND_ROM;
                w_wait = WAIT_W'(ROM_WAIT);
                w_err  = i_req_write;
            end
            RGN_RAM: begin
                w_kind = KIND_RAM;
                w_wait = WAIT_W'(RAM_WAIT);
                w_err  = (32'(w_word) >= RAM_DEPTH);
            end
            RGN_IO: begin
                w_kind = KIND_IO;
                w_wait = WAIT_W'(IO_WAIT);
                w_err  = (i_req_addr[11:6] != '0) || (32'(w_word[3:0]) >= NUM_IO);
            end
            default: w_err = 1'b1;
        endcase
        if (i_req_addr[1:0] != 2'b00) begin
            w_err = 1'b1;
        end
        if (w_err) begin
            w_wait = '0;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next = (w_wait != '0) ? ST_WAIT : ST_ACCESS;
            ST_WAIT:   if (r_wait_cnt == WAIT_W'(1)) w_next = ST_ACCESS;
            ST_ACCESS: w_next = ST_RESP;
            ST_RESP:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_kind     <= KIND_NONE;
            r_err      <= 1'b0;
            r_write    <= 1'b0;
            r_word     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_kind     <= w_kind;
                r_err      <= w_err;
                r_write    <= i_req_write;
                r_word     <= w_word;
                r_wdata    <= i_req_wdata;
                r_be       <= i_req_be;
                r_wait_cnt <= w_wait;
            end else if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        w_io_in_sel = '0;
        for (int i = 0; i < NUM_IO; i++) begin
            if (r_word[3:0] == 4'(i)) begin
                w_io_in_sel = i_io_in[i*WIDTH +: WIDTH];
            end
        end
    end

    // RAM strobes are gated by reset so an access in flight during reset never lands.
    assign w_ram_re = reset && (r_state == ST_ACCESS) && !r_err
                      && (r_kind == KIND_RAM) && !r_write;
    assign w_ram_be = (reset && (r_state == ST_ACCESS) && !r_err
                      && (r_kind == KIND_RAM) && r_write) ? r_be : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_IO; i++) begin
                r_io_out[i] <= '0;
            end
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_rdata_ram  <= 1'b0;
        end else if (r_state == ST_ACCESS) begin
            r_resp_err   <= r_err;
            r_resp_rdata <= '0;
            r_rdata_ram  <= 1'b0;
            if (!r_err) begin
                case (r_kind)
                    KIND_ROM: r_resp_rdata <= WIDTH'(i_rom_data);
                    KIND_RAM: r_rdata_ram  <= !r_write;
                    KIND_IO: begin
                        if (r_write) begin
                            for (int i = 0; i < NUM_IO; i++) begin
                                for (int b = 0; b < NB; b++) begin
                                    if ((r_word[3:0] == 4'(i)) && r_be[b]) begin
                                        r_io_out[i][b*8 +: 8] <= r_wdata[b*8 +: 8];
                                    end
                                end
                            end
                        end else begin
                            r_resp_rdata <= w_io_in_sel;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    exmemory_bus_ram #(
        .WIDTH (WIDTH),
        .DEPTH (RAM_DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_re    (w_ram_re),
        .i_be    (w_ram_be),
        .i_addr  (r_word[RAM_AW-1:0]),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    // RAM read data comes straight from the RAM's own read register.
    assign o_resp_rdata = r_rdata_ram ? w_ram_rdata : r_resp_rdata;
    assign o_resp_valid = (r_state == ST_RESP);
    assign o_resp_err   = r_resp_err;
    assign o_rom_addr   = r_word;

    for (genvar g = 0; g < NUM_IO; g++) begin : g_io_out
        assign o_io_out[g*WIDTH +: WIDTH] = r_io_out[g];
    end

endmodule
